// File: rtl/hack_arb_pkg.sv
// Shared constants, state type and round-robin helper for the RAM8 write arbiter.
package hack_arb_pkg;

  localparam int unsigned NREQ  = 8;
  localparam int unsigned SEL_W = 3;

  typedef enum logic {ARB, LOCKED} arb_state_e;

  // First set bit of elig, searching start, start+1, ... with wrap at NREQ.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [NREQ-1:0]  elig,
                                               input logic [SEL_W-1:0] start);
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] pick;
    pick = start;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = start + SEL_W'(i);
      if (elig[idx]) pick = idx;
    end
    return pick;
  endfunction

endpackage

// File: rtl/dmux8way.sv
// 1-to-8 demultiplexer: routes in to the output selected by sel, all others 0.
module dmux8way (
  input  logic       in,
  input  logic [2:0] sel,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g,
  output logic       h
);

  always_comb begin
    a = in && (sel == 3'd0);
    b = in && (sel == 3'd1);
    c = in && (sel == 3'd2);
    d = in && (sel == 3'd3);
    e = in && (sel == 3'd4);
    f = in && (sel == 3'd5);
    g = in && (sel == 3'd6);
    h = in && (sel == 3'd7);
  end

endmodule

// File: rtl/ram8_write_arb.sv
// Round-robin arbiter feeding one registered write per cycle into a RAM8.
// Optional grant-hold feature enabled by defining ARB_LOCK_EN.
module ram8_write_arb
  import hack_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  lock,
  input  logic [WIDTH-1:0] data [NREQ],
  input  logic             ready,
  output logic             load,
  output logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] out,
  output logic [NREQ-1:0]  gnt
);

  logic             r_load, w_load_d;
  logic [SEL_W-1:0] r_sel, w_sel_d;
  logic [WIDTH-1:0] r_out, w_out_d;
  logic [SEL_W-1:0] r_ptr, w_ptr_d;
  logic [NREQ-1:0]  w_elig;
  logic [SEL_W-1:0] w_start;
  logic [SEL_W-1:0] w_win;

  // Last cycle's winner is masked so a still-high req is not written twice.
  assign w_elig = req & ~gnt;
  assign w_win  = rr_pick(w_elig, w_start);

`ifdef ARB_LOCK_EN
  arb_state_e r_state, w_state_d;

  // Leaving LOCKED restarts the search just after the held requester.
  assign w_start = (r_state == LOCKED) ? r_sel + SEL_W'(1) : r_ptr;

  always_comb begin
    w_state_d = r_state;
    w_load_d  = 1'b0;
    w_sel_d   = r_sel;
    w_out_d   = r_out;
    w_ptr_d   = r_ptr;
    unique case (r_state)
      ARB: begin
        if (ready && (|w_elig)) begin
          w_load_d  = 1'b1;
          w_sel_d   = w_win;
          w_out_d   = data[w_win];
          w_ptr_d   = w_win + SEL_W'(1);
          w_state_d = lock[w_win] ? LOCKED : ARB;
        end
      end
      LOCKED: begin
        if (ready) begin
          if (req[r_sel] && lock[r_sel]) begin
            w_load_d = 1'b1;
            w_out_d  = data[r_sel];
          end else begin
            w_state_d = ARB;
            w_ptr_d   = w_start;
            if (|w_elig) begin
              w_load_d  = 1'b1;
              w_sel_d   = w_win;
              w_out_d   = data[w_win];
              w_ptr_d   = w_win + SEL_W'(1);
              w_state_d = lock[w_win] ? LOCKED : ARB;
            end
          end
        end
      end
      default: w_state_d = ARB;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ARB;
    else       r_state <= w_state_d;
  end
`else
  logic w_unused_lock;
  assign w_unused_lock = ^lock;
  assign w_start       = r_ptr;

  always_comb begin
    w_load_d = 1'b0;
    w_sel_d  = r_sel;
    w_out_d  = r_out;
    w_ptr_d  = r_ptr;
    if (ready && (|w_elig)) begin
      w_load_d = 1'b1;
      w_sel_d  = w_win;
      w_out_d  = data[w_win];
      w_ptr_d  = w_win + SEL_W'(1);
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_load <= 1'b0;
      r_sel  <= '0;
      r_out  <= '0;
      r_ptr  <= '0;
    end else begin
      r_load <= w_load_d;
      r_sel  <= w_sel_d;
      r_out  <= w_out_d;
      r_ptr  <= w_ptr_d;
    end
  end

  assign load = r_load;
  assign sel  = r_sel;
  assign out  = r_out;

  dmux8way u_dmux (
    .in  (r_load),
    .sel (r_sel),
    .a   (gnt[0]),
    .b   (gnt[1]),
    .c   (gnt[2]),
    .d   (gnt[3]),
    .e   (gnt[4]),
    .f   (gnt[5]),
    .g   (gnt[6]),
    .h   (gnt[7])
  );

endmodule

// File: tb/tb_ram8_write_arb.sv
// Self-checking bench for ram8_write_arb: directed table, hand sequences, random vs model.
module tb_ram8_write_arb;
  import hack_arb_pkg::*;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    req = '0;
  logic [7:0]    lock = '0;
  logic [W-1:0]  data [8];
  logic          ready = 1'b1;
  logic          load;
  logic [2:0]    sel;
  logic [W-1:0]  out;
  logic [7:0]    gnt;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int            m_ptr;
  bit            m_load;
  int            m_sel;
  logic [W-1:0]  m_out;
  bit            m_locked;

  typedef struct {
    bit           rst;
    logic [7:0]   req;
    bit           ready;
    bit           load;
    logic [2:0]   sel;
    logic [W-1:0] out;
    logic [7:0]   gnt;
  } vec_t;

  vec_t vt[$];

  ram8_write_arb #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .lock  (lock),
    .data  (data),
    .ready (ready),
    .load  (load),
    .sel   (sel),
    .out   (out),
    .gnt   (gnt)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mkv(bit rst, logic [7:0] rq, bit rdy, bit ld, logic [2:0] s,
                               logic [W-1:0] o, logic [7:0] g);
    vec_t v;
    v.rst = rst; v.req = rq; v.ready = rdy; v.load = ld; v.sel = s; v.out = o; v.gnt = g;
    return v;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_load = 0; m_sel = 0; m_out = '0; m_locked = 0;
  endtask

  // One rising edge of the specified behaviour, from the inputs currently driven.
  task automatic model_edge();
    int  prev;
    bit  nl;
    bit  do_arb;
    bit  found;
    int  idx;
    prev   = m_load ? m_sel : -1;
    nl     = 0;
    do_arb = ready;
`ifdef ARB_LOCK_EN
    if (m_locked) begin
      do_arb = 0;
      if (ready) begin
        if (req[m_sel] && lock[m_sel]) begin
          nl    = 1;
          m_out = data[m_sel];
        end else begin
          m_locked = 0;
          m_ptr    = (m_sel + 1) % 8;
          do_arb   = 1;
        end
      end
    end
`endif
    if (do_arb) begin
      found = 0;
      for (int k = 0; k < 8; k++) begin
        idx = (m_ptr + k) % 8;
        if (!found && req[idx] && idx != prev) begin
          found = 1;
          nl    = 1;
          m_sel = idx;
          m_out = data[idx];
`ifdef ARB_LOCK_EN
          m_locked = lock[idx];
`endif
        end
      end
      if (found) m_ptr = (m_sel + 1) % 8;
    end
    m_load = nl;
  endtask

  task automatic check_model(input string tag);
    logic [7:0] eg;
    eg = m_load ? (8'h01 << m_sel) : 8'h00;
    chk({tag, "_load"}, {31'd0, load}, {31'd0, m_load});
    chk({tag, "_sel"}, {29'd0, sel}, m_sel);
    chk({tag, "_out"}, {16'd0, out}, {16'd0, m_out});
    chk({tag, "_gnt"}, {24'd0, gnt}, {24'd0, eg});
    chk({tag, "_onehot"}, {31'd0, ($countones(gnt) <= 1)}, 32'd1);
  endtask

  task automatic step_model(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  // Called away from the clock edge; checks the asynchronous clear immediately.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    chk({tag, "_rst_load"}, {31'd0, load}, 32'd0);
    chk({tag, "_rst_gnt"}, {24'd0, gnt}, 32'd0);
    chk({tag, "_rst_sel"}, {29'd0, sel}, 32'd0);
    chk({tag, "_rst_out"}, {16'd0, out}, 32'd0);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) data[i] = 16'h1111 * W'((i == 0) ? 1 : i);
    model_reset();

    // Reset held across the first edge
    #12;
    chk("init_load", {31'd0, load}, 32'd0);
    chk("init_gnt", {24'd0, gnt}, 32'd0);
    chk("init_sel", {29'd0, sel}, 32'd0);
    chk("init_out", {16'd0, out}, 32'd0);
    reset = 1'b0;

    // Idle, alternating pair, single requester, ready backpressure
    vt.push_back(mkv(0, 8'h00, 1, 0, 3'd0, 16'h0000, 8'h00));
    vt.push_back(mkv(0, 8'h00, 1, 0, 3'd0, 16'h0000, 8'h00));
    vt.push_back(mkv(0, 8'h00, 1, 0, 3'd0, 16'h0000, 8'h00));
    vt.push_back(mkv(0, 8'h81, 1, 1, 3'd0, 16'h1111, 8'h01));
    vt.push_back(mkv(0, 8'h81, 1, 1, 3'd7, 16'h7777, 8'h80));
    vt.push_back(mkv(0, 8'h81, 1, 1, 3'd0, 16'h1111, 8'h01));
    vt.push_back(mkv(0, 8'h81, 1, 1, 3'd7, 16'h7777, 8'h80));
    vt.push_back(mkv(0, 8'h08, 1, 1, 3'd3, 16'h3333, 8'h08));
    vt.push_back(mkv(0, 8'h08, 1, 0, 3'd3, 16'h3333, 8'h00));
    vt.push_back(mkv(0, 8'h08, 1, 1, 3'd3, 16'h3333, 8'h08));
    vt.push_back(mkv(0, 8'h08, 1, 0, 3'd3, 16'h3333, 8'h00));
    vt.push_back(mkv(1, 8'h00, 1, 0, 3'd0, 16'h0000, 8'h00));
    vt.push_back(mkv(0, 8'hFF, 1, 1, 3'd0, 16'h1111, 8'h01));
    vt.push_back(mkv(0, 8'hFF, 1, 1, 3'd1, 16'h1111, 8'h02));
    vt.push_back(mkv(0, 8'hFF, 0, 0, 3'd1, 16'h1111, 8'h00));
    vt.push_back(mkv(0, 8'hFF, 0, 0, 3'd1, 16'h1111, 8'h00));
    vt.push_back(mkv(0, 8'hFF, 0, 0, 3'd1, 16'h1111, 8'h00));
    vt.push_back(mkv(0, 8'hFF, 1, 1, 3'd2, 16'h2222, 8'h04));

    foreach (vt[i]) begin
      if (vt[i].rst) begin
        do_reset($sformatf("vec%0d", i));
      end else begin
        req   = vt[i].req;
        ready = vt[i].ready;
        @(posedge clk);
        model_edge();
        #1;
        chk($sformatf("vec%0d_load", i), {31'd0, load}, {31'd0, vt[i].load});
        chk($sformatf("vec%0d_sel", i), {29'd0, sel}, {29'd0, vt[i].sel});
        chk($sformatf("vec%0d_out", i), {16'd0, out}, {16'd0, vt[i].out});
        chk($sformatf("vec%0d_gnt", i), {24'd0, gnt}, {24'd0, vt[i].gnt});
      end
    end

`ifdef ARB_LOCK_EN
    // Held grant on idx1 for four cycles, then release hands over to idx2
    do_reset("lk");
    req = 8'h06; lock = 8'h02; ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step_model($sformatf("lk%0d", i));
      chk($sformatf("lk%0d_gnt_c", i), {24'd0, gnt}, 32'h02);
    end
    chk("lk_ptr", {29'd0, dut.r_ptr}, 32'd2);
    lock = 8'h00;
    step_model("lk_rel");
    chk("lk_rel_gnt_c", {24'd0, gnt}, 32'h04);
`endif

    // Asynchronous reset mid-cycle while idx5 holds the grant
    do_reset("mr");
    req = 8'h20; lock = 8'h20; ready = 1'b1;
    step_model("mr_a");
    step_model("mr_b");
    #3;
    do_reset("mr_mid");
    req = 8'h21; lock = 8'h00;
    step_model("mr_after");
    chk("mr_after_gnt_c", {24'd0, gnt}, 32'h01);

    // Randomised traffic, backpressure, locks and occasional resets
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 2))
        0:       req = 8'($urandom);
        1:       req = 8'($urandom) & 8'($urandom);
        default: req = 8'(1 << $urandom_range(0, 7)) | 8'(1 << $urandom_range(0, 7));
      endcase
      lock  = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 8; i++) data[i] = W'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        do_reset("rnd");
      end else begin
        step_model("rnd");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
